// File: rtl/lstm_delta_pkg.sv
// Shared types and constants for the LSTM backprop delta sequencer.
//   state_e     : sequencer FSM states.
//   op_kind_e   : arithmetic unit operation.
//   src_sel_e   : micro-op source select (latched operands, scratch registers, ONE).
//   dst_sel_e   : micro-op destination select (scratch and result registers).
//   micro_op_t  : one ROM entry {kind, src_a, src_b, dst}.
//   OpRom       : the 24-step micro-program computing dh, ds and the four gate deltas.
//   fxp_one()   : fixed-point 1.0 for a given fraction width.
package lstm_delta_pkg;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    typedef enum logic [1:0] {OpAdd, OpSub, OpMul} op_kind_e;

    // The first NumOperands encodings index the latched operand array directly.
    typedef enum logic [4:0] {
        SrcAt, SrcIt, SrcFt, SrcOt, SrcTanh, SrcH, SrcT, SrcDout, SrcDsNx, SrcFNx, SrcCPrev,
        SrcR0, SrcR1, SrcR2, SrcR3, SrcDh, SrcDs, SrcOne
    } src_sel_e;

    typedef enum logic [3:0] {
        DstR0, DstR1, DstR2, DstR3, DstDh, DstDs, DstDa, DstDi, DstDf, DstDo
    } dst_sel_e;

    typedef struct packed {
        op_kind_e kind;
        src_sel_e src_a;
        src_sel_e src_b;
        dst_sel_e dst;
    } micro_op_t;

    localparam int unsigned NumOps      = 24;
    localparam int unsigned CntW        = 5;
    localparam int unsigned NumOperands = 11;
    localparam int unsigned NumSrc      = 18;

    localparam micro_op_t OpRom [NumOps] = '{
        '{OpSub, SrcH,    SrcT,     DstR0},  // r0 = h - t
        '{OpAdd, SrcR0,   SrcDout,  DstDh},  // dh = r0 + d_out
        '{OpMul, SrcTanh, SrcTanh,  DstR1},  // r1 = tanh_s^2
        '{OpSub, SrcOne,  SrcR1,    DstR1},  // r1 = 1 - tanh_s^2
        '{OpMul, SrcDh,   SrcOt,    DstR2},
        '{OpMul, SrcR2,   SrcR1,    DstR2},
        '{OpMul, SrcDsNx, SrcFNx,   DstR3},
        '{OpAdd, SrcR2,   SrcR3,    DstDs},  // ds, also mirrored to d_state
        '{OpMul, SrcAt,   SrcAt,    DstR1},
        '{OpSub, SrcOne,  SrcR1,    DstR1},
        '{OpMul, SrcDs,   SrcIt,    DstR2},
        '{OpMul, SrcR2,   SrcR1,    DstDa},
        '{OpSub, SrcOne,  SrcIt,    DstR1},
        '{OpMul, SrcIt,   SrcR1,    DstR1},
        '{OpMul, SrcDs,   SrcAt,    DstR2},
        '{OpMul, SrcR2,   SrcR1,    DstDi},
        '{OpSub, SrcOne,  SrcFt,    DstR1},
        '{OpMul, SrcFt,   SrcR1,    DstR1},
        '{OpMul, SrcDs,   SrcCPrev, DstR2},
        '{OpMul, SrcR2,   SrcR1,    DstDf},
        '{OpSub, SrcOne,  SrcOt,    DstR1},
        '{OpMul, SrcOt,   SrcR1,    DstR1},
        '{OpMul, SrcDh,   SrcTanh,  DstR2},
        '{OpMul, SrcR2,   SrcR1,    DstDo}
    };

    function automatic logic [63:0] fxp_one(input int unsigned frac);
        return 64'd1 << frac;
    endfunction

endpackage

// File: rtl/fxp_arith_unit.sv
// Combinational signed fixed-point multiply and add/sub.
//   op_i  : OpAdd / OpSub / OpMul.
//   a_i   : first operand (minuend for OpSub).
//   b_i   : second operand.
//   y_o   : result; multiply is floor(a*b / 2^FRAC), add/sub is WIDTH-bit.
//   ovf_o : result did not fit in WIDTH signed bits.
// Build option: DELTA_SAT_EN clamps overflowing results to the signed max/min;
// otherwise results wrap.
module fxp_arith_unit
    import lstm_delta_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FRAC  = 24
) (
    input  op_kind_e          op_i,
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    output logic [WIDTH-1:0]  y_o,
    output logic              ovf_o
);

    localparam int unsigned PW = 2 * WIDTH;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    prod_sh;
    logic signed [WIDTH:0]   sum;
    logic [WIDTH-1:0]        wrap_res;

    assign a_s = a_i;
    assign b_s = b_i;

    always_comb begin
        prod    = PW'(a_s) * PW'(b_s);
        prod_sh = prod >>> FRAC;
        sum     = (op_i == OpSub) ? ((WIDTH+1)'(a_s) - (WIDTH+1)'(b_s))
                                  : ((WIDTH+1)'(a_s) + (WIDTH+1)'(b_s));
        if (op_i == OpMul) begin
            wrap_res = prod_sh[WIDTH-1:0];
            // Fits only if every bit above the kept sign bit equals it.
            ovf_o    = (prod_sh[PW-1:WIDTH-1] != {(WIDTH+1){prod_sh[PW-1]}});
        end else begin
            wrap_res = sum[WIDTH-1:0];
            ovf_o    = sum[WIDTH] ^ sum[WIDTH-1];
        end
    end

`ifdef DELTA_SAT_EN
    logic res_neg;
    always_comb begin
        res_neg = (op_i == OpMul) ? prod_sh[PW-1] : sum[WIDTH];
        if (ovf_o) begin
            y_o = res_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            y_o = wrap_res;
        end
    end
`else
    assign y_o = wrap_res;
`endif

endmodule

// File: rtl/lstm_delta_seq.sv
// Self-sequenced LSTM backprop delta unit: one cell per transaction, 24 micro-ops on one
// shared fxp_arith_unit, operands latched on accept.
//   clk, rst            : clock, synchronous active-high reset.
//   in_valid / in_ready : operand bundle handshake (ready only when idle).
//   at, it, ft, ot      : forward gate activations.
//   tanh_s, h, t, d_out : tanh(state), cell output, label, recurrent output delta.
//   d_state_nx, f_nx    : state delta and forget gate of step t+1.
//   c_prev              : state at step t-1.
//   out_valid/out_ready : result handshake; results held while out_ready is low.
//   d_a, d_i, d_f, d_o, d_state : result deltas.
//   sat_flag            : (DELTA_SAT_EN only) any clamp during the transaction.
// Build option: DELTA_SAT_EN enables saturating arithmetic and the sat_flag port.
module lstm_delta_seq
    import lstm_delta_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FRAC  = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] at,
    input  logic [WIDTH-1:0] it,
    input  logic [WIDTH-1:0] ft,
    input  logic [WIDTH-1:0] ot,
    input  logic [WIDTH-1:0] tanh_s,
    input  logic [WIDTH-1:0] h,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] d_out,
    input  logic [WIDTH-1:0] d_state_nx,
    input  logic [WIDTH-1:0] f_nx,
    input  logic [WIDTH-1:0] c_prev,
`ifdef DELTA_SAT_EN
    output logic             sat_flag,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d_a,
    output logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] d_f,
    output logic [WIDTH-1:0] d_o,
    output logic [WIDTH-1:0] d_state
);

    localparam logic [WIDTH-1:0] One = WIDTH'(fxp_one(FRAC));

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              accept, calc_en, last_op;

    logic [WIDTH-1:0]  opnd_q [NumOperands];
    logic [WIDTH-1:0]  r0_q, r1_q, r2_q, r3_q, dh_q, ds_q;
    logic [WIDTH-1:0]  d_a_q, d_i_q, d_f_q, d_o_q, d_state_q;

    micro_op_t         uop;
    logic [WIDTH-1:0]  src_vec [NumSrc];
    logic [WIDTH-1:0]  alu_a, alu_b, alu_y;
    logic              alu_ovf;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid)  state_d = StCalc;
            StCalc:  if (last_op)   state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default:                state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        accept    = in_ready && in_valid;
        calc_en   = (state_q == StCalc);
    end

    // ---------------- Op counter ----------------
    assign last_op = (cnt_q == CntW'(NumOps - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (calc_en) begin
            // Wrap to 0 after the last op so the ROM is never indexed out of range.
            cnt_d = last_op ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ---------------- Datapath ----------------
    assign uop = OpRom[cnt_q];

    always_comb begin
        for (int k = 0; k < NumSrc; k++) begin
            src_vec[k] = '0;
        end
        for (int k = 0; k < NumOperands; k++) begin
            src_vec[k] = opnd_q[k];
        end
        src_vec[SrcR0]  = r0_q;
        src_vec[SrcR1]  = r1_q;
        src_vec[SrcR2]  = r2_q;
        src_vec[SrcR3]  = r3_q;
        src_vec[SrcDh]  = dh_q;
        src_vec[SrcDs]  = ds_q;
        src_vec[SrcOne] = One;
        alu_a = src_vec[uop.src_a];
        alu_b = src_vec[uop.src_b];
    end

    fxp_arith_unit #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_arith (
        .op_i  (uop.kind),
        .a_i   (alu_a),
        .b_i   (alu_b),
        .y_o   (alu_y),
        .ovf_o (alu_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NumOperands; k++) begin
                opnd_q[k] <= '0;
            end
            r0_q      <= '0;
            r1_q      <= '0;
            r2_q      <= '0;
            r3_q      <= '0;
            dh_q      <= '0;
            ds_q      <= '0;
            d_a_q     <= '0;
            d_i_q     <= '0;
            d_f_q     <= '0;
            d_o_q     <= '0;
            d_state_q <= '0;
        end else if (accept) begin
            opnd_q[SrcAt]    <= at;
            opnd_q[SrcIt]    <= it;
            opnd_q[SrcFt]    <= ft;
            opnd_q[SrcOt]    <= ot;
            opnd_q[SrcTanh]  <= tanh_s;
            opnd_q[SrcH]     <= h;
            opnd_q[SrcT]     <= t;
            opnd_q[SrcDout]  <= d_out;
            opnd_q[SrcDsNx]  <= d_state_nx;
            opnd_q[SrcFNx]   <= f_nx;
            opnd_q[SrcCPrev] <= c_prev;
        end else if (calc_en) begin
            unique case (uop.dst)
                DstR0: r0_q  <= alu_y;
                DstR1: r1_q  <= alu_y;
                DstR2: r2_q  <= alu_y;
                DstR3: r3_q  <= alu_y;
                DstDh: dh_q  <= alu_y;
                DstDs: begin
                    ds_q      <= alu_y;
                    d_state_q <= alu_y;
                end
                DstDa: d_a_q <= alu_y;
                DstDi: d_i_q <= alu_y;
                DstDf: d_f_q <= alu_y;
                DstDo: d_o_q <= alu_y;
                default: ;
            endcase
        end
    end

`ifdef DELTA_SAT_EN
    logic sat_q;
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            sat_q <= 1'b0;
        end else if (calc_en && alu_ovf) begin
            sat_q <= 1'b1;
        end
    end
    assign sat_flag = sat_q;
`else
    logic unused_alu_ovf;
    assign unused_alu_ovf = alu_ovf;
`endif

    assign d_a     = d_a_q;
    assign d_i     = d_i_q;
    assign d_f     = d_f_q;
    assign d_o     = d_o_q;
    assign d_state = d_state_q;

endmodule

// File: tb/tb_lstm_delta_seq.sv
module tb_lstm_delta_seq;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] at, it, ft, ot, tanh_s, h, t, d_out, d_state_nx, f_nx, c_prev;
    logic [31:0] d_a, d_i, d_f, d_o, d_state;
`ifdef DELTA_SAT_EN
    logic        sat_flag;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lstm_delta_seq #(
        .WIDTH (32),
        .FRAC  (24)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .at         (at),
        .it         (it),
        .ft         (ft),
        .ot         (ot),
        .tanh_s     (tanh_s),
        .h          (h),
        .t          (t),
        .d_out      (d_out),
        .d_state_nx (d_state_nx),
        .f_nx       (f_nx),
        .c_prev     (c_prev),
`ifdef DELTA_SAT_EN
        .sat_flag   (sat_flag),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .d_a        (d_a),
        .d_i        (d_i),
        .d_f        (d_f),
        .d_o        (d_o),
        .d_state    (d_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic set_basic();
        h = 32'h0100_0000; t = 32'h0; d_out = 32'h0; ot = 32'h0100_0000; tanh_s = 32'h0;
        d_state_nx = 32'h0; f_nx = 32'h0; at = 32'h0; it = 32'h0100_0000;
        ft = 32'h0080_0000; c_prev = 32'h0;
    endtask

    task automatic set_mixed();
        h = 32'h0080_0000; t = 32'h0; d_out = 32'h0040_0000;
        ot = 32'h0080_0000; it = 32'h0080_0000; at = 32'h0080_0000;
        ft = 32'h0080_0000; tanh_s = 32'h0080_0000;
        d_state_nx = 32'h0100_0000; f_nx = 32'h0080_0000; c_prev = 32'h0100_0000;
    endtask

    task automatic check_res(input string tag, input logic [31:0] e_s, input logic [31:0] e_a,
                             input logic [31:0] e_i, input logic [31:0] e_f,
                             input logic [31:0] e_o);
        check_eq({tag, ".d_state"}, d_state, e_s);
        check_eq({tag, ".d_a"}, d_a, e_a);
        check_eq({tag, ".d_i"}, d_i, e_i);
        check_eq({tag, ".d_f"}, d_f, e_f);
        check_eq({tag, ".d_o"}, d_o, e_o);
    endtask

    // Called at a negedge while idle; returns at the negedge after the accept edge.
    task automatic accept_bundle(input string tag);
        check_eq({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // 'start' is the number of cycles already elapsed since the accept edge.
    task automatic wait_done(input string tag, input int start);
        int lat;
        lat = start;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, ".latency"}, lat, 32'd24);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, ".in_ready_after"}, {31'b0, in_ready}, 32'd1);
        check_eq({tag, ".out_valid_after"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_basic();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check_eq("rst.in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("rst.out_valid", {31'b0, out_valid}, 32'd0);
        check_res("rst", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

        // Basic
        set_basic();
        accept_bundle("basic");
        check_eq("basic.in_ready_calc", {31'b0, in_ready}, 32'd0);
        wait_done("basic", 0);
        check_res("basic", 32'h0100_0000, 32'h0100_0000, 32'h0, 32'h0, 32'h0);
`ifdef DELTA_SAT_EN
        check_eq("basic.sat_flag", {31'b0, sat_flag}, 32'd0);
`endif
        release_out("basic");

        // Mixed with 10 cycles of backpressure
        set_mixed();
        accept_bundle("mixed");
        wait_done("mixed", 0);
        for (int k = 0; k < 10; k++) begin
            check_res("bp", 32'h00C8_0000, 32'h004B_0000, 32'h0019_0000, 32'h0032_0000,
                      32'h0018_0000);
            check_eq("bp.in_ready", {31'b0, in_ready}, 32'd0);
            check_eq("bp.out_valid", {31'b0, out_valid}, 32'd1);
            @(negedge clk);
        end
        release_out("mixed");

        // Back-to-back basic; in_valid toggled with other data during CALC is ignored
        set_basic();
        accept_bundle("b2b");
        set_mixed();
        for (int k = 0; k < 6; k++) begin
            in_valid = ~in_valid;
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_done("b2b", 6);
        check_res("b2b", 32'h0100_0000, 32'h0100_0000, 32'h0, 32'h0, 32'h0);
        release_out("b2b");

        // Overflow on h - t
        set_basic();
        h = 32'h6400_0000;
        t = 32'h9C00_0000;
        accept_bundle("ovf");
        wait_done("ovf", 0);
`ifdef DELTA_SAT_EN
        check_eq("ovf.d_state", d_state, 32'h7FFF_FFFF);
        check_eq("ovf.d_a", d_a, 32'h7FFF_FFFF);
        check_eq("ovf.sat_flag", {31'b0, sat_flag}, 32'd1);
`else
        check_eq("ovf.d_state", d_state, 32'hC800_0000);
        check_eq("ovf.d_a", d_a, 32'hC800_0000);
`endif
        check_eq("ovf.d_o", d_o, 32'h0);
        release_out("ovf");

        // Reset 10 cycles after accept, with in_valid also high: reset wins
        set_mixed();
        accept_bundle("mid");
        repeat (9) @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        check_eq("mid.in_ready", {31'b0, in_ready}, 32'd1);
        check_res("mid", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int k = 0; k < 30; k++) begin
            check_eq("mid.out_valid", {31'b0, out_valid}, 32'd0);
            @(negedge clk);
        end
        check_eq("mid.in_ready_idle", {31'b0, in_ready}, 32'd1);

        set_basic();
        accept_bundle("post");
        wait_done("post", 0);
        check_res("post", 32'h0100_0000, 32'h0100_0000, 32'h0, 32'h0, 32'h0);
`ifdef DELTA_SAT_EN
        check_eq("post.sat_flag", {31'b0, sat_flag}, 32'd0);
`endif
        release_out("post");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
